id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- ID/EX pipeline register of the in-order RV32 core, directly downstream of the register file.
- Captures decoded fields plus the register file's combinational read data into the EX stage.
- Resolves operands by forwarding from the MEM and WB stages; the register file has no internal write-to-read bypass, so the WB-stage forward is mandatory.
- Detects RAW hazards that cannot be forwarded, stalls decode and inserts bubbles.

Parameters:
- XLEN, 32, data/PC width
- ALU_OP_W, 4, width of the ALU operation code

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  decode holds a valid instruction
- id_pc  in  XLEN  instruction PC
- id_rs1, id_rs2, id_rd  in  5 each  register indices
- id_uses_rs1, id_uses_rs2  in  1 each  instruction reads rs1/rs2
- id_imm  in  XLEN  decoded immediate
- id_alu_op  in  ALU_OP_W  ALU operation
- id_reg_we, id_mem_re, id_mem_we  in  1 each  writeback / load / store flags
- rf_rdata1, rf_rdata2  in  XLEN  register file read data for id_rs1/id_rs2
- mem_valid, mem_reg_we, mem_is_load  in  1 each  MEM-stage instruction status
- mem_rd  in  5  MEM-stage destination
- mem_result  in  XLEN  MEM-stage ALU result
- wb_we  in  1  register file write enable (same-cycle)
- wb_rd  in  5  register file write index
- wb_wdata  in  XLEN  register file write data
- ex_stall  in  1  EX or a later stage cannot accept
- flush  in  1  redirect; kill the instruction in ID/EX
- id_stall  out  1  decode must hold its instruction this cycle
- ex_valid  out  1  EX holds a valid instruction
- ex_pc, ex_imm, ex_rs1_val, ex_rs2_val  out  XLEN each  registered PC, immediate and operands
- ex_rs1, ex_rs2, ex_rd  out  5 each  registered indices
- ex_alu_op  out  ALU_OP_W  registered ALU operation
- ex_reg_we, ex_mem_re, ex_mem_we  out  1 each  registered flags

Behaviour:
- Reset (async, rst_n low): every registered output is 0, including ex_valid; the output id_stall is 0.

Operand select (combinational, per source operand, evaluated with its own index):
1. Index 0 -> 0.
2. Else if mem_valid && mem_reg_we && !mem_is_load && mem_rd == index -> mem_result.
3. Else if wb_we && wb_rd == index -> wb_wdata.
4. Else the rf_rdata value.
- MEM takes priority over WB.

hazard (combinational): id_valid && an operand that is used (uses_rsN=1, index != 0) matches either of:
- ex_valid && ex_reg_we && ex_rd == index (result not yet computed), or
- mem_valid && mem_reg_we && mem_is_load && mem_rd == index (load data not ready).

id_stall = hazard || ex_stall. This is the sole source of id_stall, so id_stall is 0 whenever both are false.

Register update on each posedge clk, first match wins:
1. flush: ex_valid <= 0; other fields are don't-care. Flush dominates ex_stall and hazard.
2. ex_stall: all ex_* hold.
3. hazard: bubble; ex_valid <= 0, ex_reg_we/ex_mem_re/ex_mem_we <= 0.
4. Otherwise: load all ex_* from id_* and the selected operands; ex_valid <= id_valid.
- Whenever ex_valid is 0, ex_reg_we, ex_mem_re and ex_mem_we are also 0, so bubbles have no side effects.

Other rules:
- Latency: one cycle from ID to EX. The stage sustains one instruction per cycle absent hazards.
- A load-use dependency costs exactly 2 bubbles: one for the EX match, one for the MEM load match. An ALU-use dependency costs 1.
- rs indices are compared even when id_uses_rsN=0 but cannot cause a stall in that case.
- Reset asserted mid-stall clears the stage immediately; no instruction survives.

Test Plan:
1. After reset, drive id_valid=1, rs1=5, rf_rdata1=0x11, no writers -> next cycle ex_valid=1, ex_rs1_val=0x11, id_stall=0 throughout.
2. Same cycle wb_we=1, wb_rd=5, wb_wdata=0xAA and rf_rdata1=0x11 -> ex_rs1_val=0xAA. Add MEM writer mem_rd=5, mem_result=0xBB (non-load) -> ex_rs1_val=0xBB.
3. EX holds an ALU op to x7, decode reads x7 -> id_stall=1 for 1 cycle, one bubble (ex_valid=0), then the operand is forwarded from MEM.
4. Load to x7 followed by a dependent add -> id_stall high 2 cycles, 2 bubbles, operand taken from wb_wdata on the third cycle.
5. rs1=0 with wb_we=1, wb_rd=0, wb_wdata=0xFF, or an EX writer to x0 -> ex_rs1_val=0, no stall.
6. ex_stall=1 for 3 cycles -> ex_* unchanged and id_stall=1. Assert flush during the stall -> next cycle ex_valid=0, ex_reg_we=0, ex_mem_re=0, ex_mem_we=0.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the in-order RV32 core. It resolves MEM/WB forwarding and
// stalls decode on RAW hazards that cannot be forwarded.
module id_ex_stage #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned ALU_OP_W = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                id_valid,
  input  logic [XLEN-1:0]     id_pc,
  input  logic [4:0]          id_rs1,
  input  logic [4:0]          id_rs2,
  input  logic [4:0]          id_rd,
  input  logic                id_uses_rs1,
  input  logic                id_uses_rs2,
  input  logic [XLEN-1:0]     id_imm,
  input  logic [ALU_OP_W-1:0] id_alu_op,
  input  logic                id_reg_we,
  input  logic                id_mem_re,
  input  logic                id_mem_we,
  input  logic [XLEN-1:0]     rf_rdata1,
  input  logic [XLEN-1:0]     rf_rdata2,
  input  logic                mem_valid,
  input  logic                mem_reg_we,
  input  logic                mem_is_load,
  input  logic [4:0]          mem_rd,
  input  logic [XLEN-1:0]     mem_result,
  input  logic                wb_we,
  input  logic [4:0]          wb_rd,
  input  logic [XLEN-1:0]     wb_wdata,
  input  logic                ex_stall,
  input  logic                flush,
  output logic                id_stall,
  output logic                ex_valid,
  output logic [XLEN-1:0]     ex_pc,
  output logic [XLEN-1:0]     ex_imm,
  output logic [XLEN-1:0]     ex_rs1_val,
  output logic [XLEN-1:0]     ex_rs2_val,
  output logic [4:0]          ex_rs1,
  output logic [4:0]          ex_rs2,
  output logic [4:0]          ex_rd,
  output logic [ALU_OP_W-1:0] ex_alu_op,
  output logic                ex_reg_we,
  output logic                ex_mem_re,
  output logic                ex_mem_we
);

  logic            mem_fwd_ok;
  logic [XLEN-1:0] rs1_sel;
  logic [XLEN-1:0] rs2_sel;
  logic            rs1_hazard;
  logic            rs2_hazard;
  logic            hazard;

  // Loads in MEM have no data yet, so only non-load writers may forward from there.
  assign mem_fwd_ok = mem_valid && mem_reg_we && !mem_is_load;

  always_comb begin
    rs1_sel = rf_rdata1;
    if (id_rs1 == 5'd0) begin
      rs1_sel = '0;
    end else if (mem_fwd_ok && (mem_rd == id_rs1)) begin
      rs1_sel = mem_result;
    end else if (wb_we && (wb_rd == id_rs1)) begin
      rs1_sel = wb_wdata;
    end
  end

  always_comb begin
    rs2_sel = rf_rdata2;
    if (id_rs2 == 5'd0) begin
      rs2_sel = '0;
    end else if (mem_fwd_ok && (mem_rd == id_rs2)) begin
      rs2_sel = mem_result;
    end else if (wb_we && (wb_rd == id_rs2)) begin
      rs2_sel = wb_wdata;
    end
  end

  assign rs1_hazard = id_uses_rs1 && (id_rs1 != 5'd0) &&
                      ((ex_valid && ex_reg_we && (ex_rd == id_rs1)) ||
                       (mem_valid && mem_reg_we && mem_is_load && (mem_rd == id_rs1)));
  assign rs2_hazard = id_uses_rs2 && (id_rs2 != 5'd0) &&
                      ((ex_valid && ex_reg_we && (ex_rd == id_rs2)) ||
                       (mem_valid && mem_reg_we && mem_is_load && (mem_rd == id_rs2)));
  assign hazard     = id_valid && (rs1_hazard || rs2_hazard);
  assign id_stall   = hazard || ex_stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid   <= 1'b0;
      ex_pc      <= '0;
      ex_imm     <= '0;
      ex_rs1_val <= '0;
      ex_rs2_val <= '0;
      ex_rs1     <= '0;
      ex_rs2     <= '0;
      ex_rd      <= '0;
      ex_alu_op  <= '0;
      ex_reg_we  <= 1'b0;
      ex_mem_re  <= 1'b0;
      ex_mem_we  <= 1'b0;
    end else if (flush || (!ex_stall && hazard)) begin
      ex_valid  <= 1'b0;
      ex_reg_we <= 1'b0;
      ex_mem_re <= 1'b0;
      ex_mem_we <= 1'b0;
    end else if (!ex_stall) begin
      ex_valid   <= id_valid;
      ex_pc      <= id_pc;
      ex_imm     <= id_imm;
      ex_rs1_val <= rs1_sel;
      ex_rs2_val <= rs2_sel;
      ex_rs1     <= id_rs1;
      ex_rs2     <= id_rs2;
      ex_rd      <= id_rd;
      ex_alu_op  <= id_alu_op;
      // Side-effect flags are gated so an empty slot never writes anything.
      ex_reg_we  <= id_valid && id_reg_we;
      ex_mem_re  <= id_valid && id_mem_re;
      ex_mem_we  <= id_valid && id_mem_we;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage: forwarding vectors from a table plus
// hand-written hazard, stall, flush and reset sequences.
module tb_id_ex_stage;

  logic        clk;
  logic        rst_n;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        id_uses_rs1, id_uses_rs2;
  logic [31:0] id_imm;
  logic [3:0]  id_alu_op;
  logic        id_reg_we, id_mem_re, id_mem_we;
  logic [31:0] rf_rdata1, rf_rdata2;
  logic        mem_valid, mem_reg_we, mem_is_load;
  logic [4:0]  mem_rd;
  logic [31:0] mem_result;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_wdata;
  logic        ex_stall, flush;
  logic        id_stall, ex_valid;
  logic [31:0] ex_pc, ex_imm, ex_rs1_val, ex_rs2_val;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic [3:0]  ex_alu_op;
  logic        ex_reg_we, ex_mem_re, ex_mem_we;

  int n_checks = 0;
  int n_fail   = 0;

  id_ex_stage #(.XLEN(32), .ALU_OP_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_pc(id_pc),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_imm(id_imm),
    .id_alu_op(id_alu_op), .id_reg_we(id_reg_we), .id_mem_re(id_mem_re),
    .id_mem_we(id_mem_we), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .mem_valid(mem_valid), .mem_reg_we(mem_reg_we), .mem_is_load(mem_is_load),
    .mem_rd(mem_rd), .mem_result(mem_result), .wb_we(wb_we), .wb_rd(wb_rd),
    .wb_wdata(wb_wdata), .ex_stall(ex_stall), .flush(flush), .id_stall(id_stall),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_rs1_val(ex_rs1_val),
    .ex_rs2_val(ex_rs2_val), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_alu_op(ex_alu_op), .ex_reg_we(ex_reg_we), .ex_mem_re(ex_mem_re),
    .ex_mem_we(ex_mem_we)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [4:0]  rs1, rs2;
    logic        u1, u2;
    logic [31:0] rf1, rf2;
    logic        mv, mwe, mld;
    logic [4:0]  mrd;
    logic [31:0] mres;
    logic        wwe;
    logic [4:0]  wrd;
    logic [31:0] wdat;
    logic        e_stall, e_valid;
    logic [31:0] e_v1, e_v2;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle();
    id_valid = 0; id_pc = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0;
    id_uses_rs1 = 0; id_uses_rs2 = 0; id_imm = 0; id_alu_op = 0;
    id_reg_we = 0; id_mem_re = 0; id_mem_we = 0; rf_rdata1 = 0; rf_rdata2 = 0;
    mem_valid = 0; mem_reg_we = 0; mem_is_load = 0; mem_rd = 0; mem_result = 0;
    wb_we = 0; wb_rd = 0; wb_wdata = 0; ex_stall = 0; flush = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    rst_n = 0;
    #12;
    chk("reset_ex_valid", {31'd0, ex_valid}, 32'd0);
    chk("reset_ex_pc", ex_pc, 32'd0);
    chk("reset_ex_rs1_val", ex_rs1_val, 32'd0);
    chk("reset_ex_flags", {29'd0, ex_reg_we, ex_mem_re, ex_mem_we}, 32'd0);
    chk("reset_id_stall", {31'd0, id_stall}, 32'd0);
    @(negedge clk);
    rst_n = 1;

    //          v  rs1 rs2 u1 u2 rf1      rf2      mv mwe mld mrd mres     wwe wrd wdat     stl vld ev1      ev2
    vecs[0] = '{1, 5,  6,  1, 1, 32'h11,  32'h22,  0, 0,  0,  0,  32'h0,   0,  0,  32'h0,   0,  1,  32'h11,  32'h22};
    vecs[1] = '{1, 5,  6,  1, 1, 32'h11,  32'h22,  0, 0,  0,  0,  32'h0,   1,  5,  32'hAA,  0,  1,  32'hAA,  32'h22};
    vecs[2] = '{1, 5,  6,  1, 1, 32'h11,  32'h22,  1, 1,  0,  5,  32'hBB,  1,  5,  32'hAA,  0,  1,  32'hBB,  32'h22};
    vecs[3] = '{1, 5,  6,  1, 1, 32'h11,  32'h22,  1, 1,  0,  5,  32'hBB,  1,  6,  32'h66,  0,  1,  32'hBB,  32'h66};
    vecs[4] = '{1, 0,  6,  1, 1, 32'h123, 32'h22,  0, 0,  0,  0,  32'h0,   1,  0,  32'hFF,  0,  1,  32'h0,   32'h22};
    vecs[5] = '{1, 5,  6,  1, 1, 32'h11,  32'h22,  1, 1,  1,  5,  32'hBB,  0,  0,  32'h0,   1,  0,  32'h0,   32'h0};
    vecs[6] = '{1, 5,  6,  0, 1, 32'h11,  32'h22,  1, 1,  1,  5,  32'hBB,  0,  0,  32'h0,   0,  1,  32'h11,  32'h22};
    vecs[7] = '{1, 5,  6,  1, 1, 32'h11,  32'h22,  1, 0,  0,  6,  32'hBB,  0,  0,  32'h0,   0,  1,  32'h11,  32'h22};
    vecs[8] = '{1, 5,  6,  1, 1, 32'h11,  32'h22,  0, 1,  0,  6,  32'hBB,  1,  6,  32'h77,  0,  1,  32'h11,  32'h77};
    vecs[9] = '{0, 5,  6,  1, 1, 32'h11,  32'h22,  1, 1,  1,  5,  32'hBB,  0,  0,  32'h0,   0,  0,  32'h0,   32'h0};

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      idle();
      id_valid = vecs[i].v; id_rs1 = vecs[i].rs1; id_rs2 = vecs[i].rs2;
      id_uses_rs1 = vecs[i].u1; id_uses_rs2 = vecs[i].u2; id_reg_we = 0;
      rf_rdata1 = vecs[i].rf1; rf_rdata2 = vecs[i].rf2;
      mem_valid = vecs[i].mv; mem_reg_we = vecs[i].mwe; mem_is_load = vecs[i].mld;
      mem_rd = vecs[i].mrd; mem_result = vecs[i].mres;
      wb_we = vecs[i].wwe; wb_rd = vecs[i].wrd; wb_wdata = vecs[i].wdat;
      #1;
      chk($sformatf("vec%0d_id_stall", i), {31'd0, id_stall}, {31'd0, vecs[i].e_stall});
      step();
      chk($sformatf("vec%0d_ex_valid", i), {31'd0, ex_valid}, {31'd0, vecs[i].e_valid});
      if (vecs[i].e_valid) begin
        chk($sformatf("vec%0d_rs1_val", i), ex_rs1_val, vecs[i].e_v1);
        chk($sformatf("vec%0d_rs2_val", i), ex_rs2_val, vecs[i].e_v2);
      end else begin
        chk($sformatf("vec%0d_bubble_flags", i), {29'd0, ex_reg_we, ex_mem_re, ex_mem_we},
            32'd0);
      end
    end

    // ALU-use: one bubble, then forward from MEM
    @(negedge clk); idle();
    id_valid = 1; id_rd = 7; id_reg_we = 1; id_alu_op = 4'h3;
    step();
    chk("alu_ex_rd", {27'd0, ex_rd}, 32'd7);
    @(negedge clk); idle();
    id_valid = 1; id_rs1 = 7; id_uses_rs1 = 1; rf_rdata1 = 32'h1;
    #1 chk("alu_stall_c1", {31'd0, id_stall}, 32'd1);
    step();
    chk("alu_bubble", {30'd0, ex_valid, ex_reg_we}, 32'd0);
    @(negedge clk);
    mem_valid = 1; mem_reg_we = 1; mem_rd = 7; mem_result = 32'h777;
    #1 chk("alu_stall_c2", {31'd0, id_stall}, 32'd0);
    step();
    chk("alu_fwd_valid", {31'd0, ex_valid}, 32'd1);
    chk("alu_fwd_val", ex_rs1_val, 32'h777);

    // Load-use: two bubbles, then forward from WB
    @(negedge clk); idle();
    id_valid = 1; id_rd = 7; id_reg_we = 1; id_mem_re = 1;
    step();
    @(negedge clk); idle();
    id_valid = 1; id_rs1 = 7; id_uses_rs1 = 1; rf_rdata1 = 32'h1;
    #1 chk("ld_stall_c1", {31'd0, id_stall}, 32'd1);
    step();
    chk("ld_bubble1", {31'd0, ex_valid}, 32'd0);
    @(negedge clk);
    mem_valid = 1; mem_reg_we = 1; mem_is_load = 1; mem_rd = 7;
    #1 chk("ld_stall_c2", {31'd0, id_stall}, 32'd1);
    step();
    chk("ld_bubble2", {31'd0, ex_valid}, 32'd0);
    @(negedge clk);
    mem_valid = 0; mem_reg_we = 0; mem_is_load = 0;
    wb_we = 1; wb_rd = 7; wb_wdata = 32'hDEAD;
    #1 chk("ld_stall_c3", {31'd0, id_stall}, 32'd0);
    step();
    chk("ld_fwd_valid", {31'd0, ex_valid}, 32'd1);
    chk("ld_fwd_val", ex_rs1_val, 32'hDEAD);

    // EX writer to x0 never stalls a reader of x0
    @(negedge clk); idle();
    id_valid = 1; id_rd = 0; id_reg_we = 1;
    step();
    @(negedge clk); idle();
    id_valid = 1; id_rs1 = 0; id_uses_rs1 = 1; rf_rdata1 = 32'h55;
    #1 chk("x0_no_stall", {31'd0, id_stall}, 32'd0);
    step();
    chk("x0_val", ex_rs1_val, 32'd0);

    // ex_stall holds everything, then flush kills the slot
    @(negedge clk); idle();
    id_valid = 1; id_pc = 32'h100; id_imm = 32'h44; id_rd = 9; id_reg_we = 1;
    id_mem_re = 1; id_mem_we = 1; id_alu_op = 4'hA;
    step();
    chk("hold_pre_pc", ex_pc, 32'h100);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); idle();
      ex_stall = 1; id_valid = 1; id_pc = 32'h200; id_imm = 32'h99; id_rd = 3;
      #1 chk($sformatf("hold%0d_id_stall", c), {31'd0, id_stall}, 32'd1);
      step();
      chk($sformatf("hold%0d_pc", c), ex_pc, 32'h100);
      chk($sformatf("hold%0d_imm_rd", c), {ex_imm[15:0], 11'd0, ex_rd}, {16'h44, 11'd0, 5'd9});
      chk($sformatf("hold%0d_flags", c), {28'd0, ex_valid, ex_reg_we, ex_mem_re, ex_mem_we},
          32'hF);
    end
    @(negedge clk);
    flush = 1;
    step();
    chk("flush_kill", {28'd0, ex_valid, ex_reg_we, ex_mem_re, ex_mem_we}, 32'd0);

    // Reset in the middle of a stall
    @(negedge clk); idle();
    id_valid = 1; id_pc = 32'h300; id_reg_we = 1;
    step();
    @(negedge clk);
    ex_stall = 1;
    #2 rst_n = 0;
    #1;
    chk("rst_mid_valid", {30'd0, ex_valid, ex_reg_we}, 32'd0);
    chk("rst_mid_pc", ex_pc, 32'd0);
    @(negedge clk);
    ex_stall = 0;
    rst_n = 1;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
